// File: rtl/axi_rd_arbiter.sv
// Two-master AXI read-channel arbiter: IFU and LSU share one AR/R port, locked per transaction.
// Round-robin on simultaneous requests; R beats are counted against ARLEN to flag protocol errors.
module axi_rd_arbiter #(
    parameter int ID_W   = 5,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ID_W-1:0]   ifu_ar_id,
    input  logic [ADDR_W-1:0] ifu_ar_addr,
    input  logic [7:0]        ifu_ar_len,
    input  logic [2:0]        ifu_ar_size,
    input  logic [1:0]        ifu_ar_burst,
    input  logic              ifu_ar_valid,
    output logic              ifu_ar_ready,
    output logic [ID_W-1:0]   ifu_r_id,
    output logic [DATA_W-1:0] ifu_r_data,
    output logic [1:0]        ifu_r_resp,
    output logic              ifu_r_last,
    output logic              ifu_r_valid,
    input  logic              ifu_r_ready,

    input  logic [ID_W-1:0]   lsu_ar_id,
    input  logic [ADDR_W-1:0] lsu_ar_addr,
    input  logic [7:0]        lsu_ar_len,
    input  logic [2:0]        lsu_ar_size,
    input  logic [1:0]        lsu_ar_burst,
    input  logic              lsu_ar_valid,
    output logic              lsu_ar_ready,
    output logic [ID_W-1:0]   lsu_r_id,
    output logic [DATA_W-1:0] lsu_r_data,
    output logic [1:0]        lsu_r_resp,
    output logic              lsu_r_last,
    output logic              lsu_r_valid,
    input  logic              lsu_r_ready,

    output logic [ID_W-1:0]   m_ar_id,
    output logic [ADDR_W-1:0] m_ar_addr,
    output logic [7:0]        m_ar_len,
    output logic [2:0]        m_ar_size,
    output logic [1:0]        m_ar_burst,
    output logic              m_ar_valid,
    input  logic              m_ar_ready,
    input  logic [ID_W-1:0]   m_r_id,
    input  logic [DATA_W-1:0] m_r_data,
    input  logic [1:0]        m_r_resp,
    input  logic              m_r_last,
    input  logic              m_r_valid,
    output logic              m_r_ready,

    output logic              busy,
    output logic              rd_err
);

    typedef enum logic [2:0] {IDLE, IFU_AR, IFU_R, LSU_AR, LSU_R} state_e;

    state_e            state_q;
    logic              last_lsu_q;
    logic [8:0]        beat_cnt_q;
    logic [7:0]        len_q;
    logic [ID_W-1:0]   id_q;
    logic              rd_err_q;
    logic              rd_err_d;
    logic              r_phase;
    logic              ar_hs;
    logic              r_hs;
    logic              at_len;

    // Combinational steering: the owner's bundle is passed straight through, everything else is zero.
    always_comb begin
        m_ar_id      = '0;
        m_ar_addr    = '0;
        m_ar_len     = '0;
        m_ar_size    = '0;
        m_ar_burst   = '0;
        m_ar_valid   = 1'b0;
        ifu_ar_ready = 1'b0;
        lsu_ar_ready = 1'b0;
        ifu_r_id     = '0;
        ifu_r_data   = '0;
        ifu_r_resp   = '0;
        ifu_r_last   = 1'b0;
        ifu_r_valid  = 1'b0;
        lsu_r_id     = '0;
        lsu_r_data   = '0;
        lsu_r_resp   = '0;
        lsu_r_last   = 1'b0;
        lsu_r_valid  = 1'b0;
        m_r_ready    = 1'b0;
        case (state_q)
            IFU_AR: begin
                m_ar_id      = ifu_ar_id;
                m_ar_addr    = ifu_ar_addr;
                m_ar_len     = ifu_ar_len;
                m_ar_size    = ifu_ar_size;
                m_ar_burst   = ifu_ar_burst;
                m_ar_valid   = ifu_ar_valid;
                ifu_ar_ready = m_ar_ready;
            end
            LSU_AR: begin
                m_ar_id      = lsu_ar_id;
                m_ar_addr    = lsu_ar_addr;
                m_ar_len     = lsu_ar_len;
                m_ar_size    = lsu_ar_size;
                m_ar_burst   = lsu_ar_burst;
                m_ar_valid   = lsu_ar_valid;
                lsu_ar_ready = m_ar_ready;
            end
            IFU_R: begin
                ifu_r_id    = m_r_id;
                ifu_r_data  = m_r_data;
                ifu_r_resp  = m_r_resp;
                ifu_r_last  = m_r_last;
                ifu_r_valid = m_r_valid;
                m_r_ready   = ifu_r_ready;
            end
            LSU_R: begin
                lsu_r_id    = m_r_id;
                lsu_r_data  = m_r_data;
                lsu_r_resp  = m_r_resp;
                lsu_r_last  = m_r_last;
                lsu_r_valid = m_r_valid;
                m_r_ready   = lsu_r_ready;
            end
            default: ;
        endcase
    end

    assign r_phase = (state_q == IFU_R) || (state_q == LSU_R);
    assign ar_hs   = m_ar_valid & m_ar_ready;
    assign r_hs    = m_r_valid & m_r_ready;
    assign at_len  = (beat_cnt_q == {1'b0, len_q});

    // Last must coincide exactly with beat len; any beat outside the R window is a stray.
    always_comb begin
        rd_err_d = rd_err_q;
        if (r_phase) begin
            if ((m_r_valid && (m_r_id != id_q)) || (r_hs && (m_r_last != at_len)))
                rd_err_d = 1'b1;
        end else if (m_r_valid) begin
            rd_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_lsu_q <= 1'b0;
            beat_cnt_q <= '0;
            len_q      <= '0;
            id_q       <= '0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_err_q <= rd_err_d;
            case (state_q)
                IDLE: begin
                    if (lsu_ar_valid && (!ifu_ar_valid || !last_lsu_q)) begin
                        state_q    <= LSU_AR;
                        last_lsu_q <= 1'b1;
                    end else if (ifu_ar_valid) begin
                        state_q    <= IFU_AR;
                        last_lsu_q <= 1'b0;
                    end
                end
                IFU_AR, LSU_AR: begin
                    if (ar_hs) begin
                        len_q      <= m_ar_len;
                        id_q       <= m_ar_id;
                        beat_cnt_q <= '0;
                        state_q    <= (state_q == IFU_AR) ? IFU_R : LSU_R;
                    end
                end
                IFU_R, LSU_R: begin
                    if (r_hs) begin
                        beat_cnt_q <= beat_cnt_q + 9'd1;
                        if (m_r_last)
                            state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy   = (state_q != IDLE);
    assign rd_err = rd_err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed scenarios with literal expectations plus randomized traffic,
// all checked every cycle against a transaction-level model of ownership, beat count and error rules.
module tb_axi_rd_arbiter;
    localparam int ID_W = 5, ADDR_W = 64, DATA_W = 64;

    logic clk = 1'b0, rst;
    logic [ID_W-1:0] ifu_ar_id, lsu_ar_id, m_ar_id, ifu_r_id, lsu_r_id, m_r_id;
    logic [ADDR_W-1:0] ifu_ar_addr, lsu_ar_addr, m_ar_addr;
    logic [7:0] ifu_ar_len, lsu_ar_len, m_ar_len;
    logic [2:0] ifu_ar_size, lsu_ar_size, m_ar_size;
    logic [1:0] ifu_ar_burst, lsu_ar_burst, m_ar_burst;
    logic ifu_ar_valid, lsu_ar_valid, m_ar_valid, ifu_ar_ready, lsu_ar_ready, m_ar_ready;
    logic [DATA_W-1:0] ifu_r_data, lsu_r_data, m_r_data;
    logic [1:0] ifu_r_resp, lsu_r_resp, m_r_resp;
    logic ifu_r_last, lsu_r_last, m_r_last, ifu_r_valid, lsu_r_valid, m_r_valid;
    logic ifu_r_ready, lsu_r_ready, m_r_ready, busy, rd_err;

    axi_rd_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .ifu_ar_id(ifu_ar_id), .ifu_ar_addr(ifu_ar_addr), .ifu_ar_len(ifu_ar_len),
        .ifu_ar_size(ifu_ar_size), .ifu_ar_burst(ifu_ar_burst), .ifu_ar_valid(ifu_ar_valid),
        .ifu_ar_ready(ifu_ar_ready), .ifu_r_id(ifu_r_id), .ifu_r_data(ifu_r_data),
        .ifu_r_resp(ifu_r_resp), .ifu_r_last(ifu_r_last), .ifu_r_valid(ifu_r_valid),
        .ifu_r_ready(ifu_r_ready),
        .lsu_ar_id(lsu_ar_id), .lsu_ar_addr(lsu_ar_addr), .lsu_ar_len(lsu_ar_len),
        .lsu_ar_size(lsu_ar_size), .lsu_ar_burst(lsu_ar_burst), .lsu_ar_valid(lsu_ar_valid),
        .lsu_ar_ready(lsu_ar_ready), .lsu_r_id(lsu_r_id), .lsu_r_data(lsu_r_data),
        .lsu_r_resp(lsu_r_resp), .lsu_r_last(lsu_r_last), .lsu_r_valid(lsu_r_valid),
        .lsu_r_ready(lsu_r_ready),
        .m_ar_id(m_ar_id), .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_size(m_ar_size),
        .m_ar_burst(m_ar_burst), .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
        .m_r_id(m_r_id), .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_last(m_r_last),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
        .busy(busy), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    bit en = 1'b0, rnd = 1'b0;

    // Model: phase 0 idle, 1 address, 2 data; owner 1=IFU 2=LSU; last grant starts at IFU.
    int md_ph = 0, md_g = 1, md_lg = 1, md_cnt = 0, md_len = 0;
    logic [ID_W-1:0] md_id = '0;
    logic md_err = 1'b0;

    // Snapshots of DUT outputs taken at the sampling edge of the last step.
    logic s_busy, s_err, s_mav, s_iarr, s_larr, s_irv, s_lrv, s_mrr;
    logic [ADDR_W-1:0] s_maddr;
    logic [ID_W-1:0] s_mid;
    logic [DATA_W-1:0] s_ird;

    // Random traffic bookkeeping.
    bit ifu_req, lsu_req, s_act;
    logic [ID_W-1:0] s_id;
    int s_len, s_beat;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_cycle();
        logic [127:0] e_mar, e_ir, e_lr, rb;
        logic e_iar, e_lar, e_mrr, gv, rdy;
        e_mar = '0; e_ir = '0; e_lr = '0; e_iar = 1'b0; e_lar = 1'b0; e_mrr = 1'b0;
        rb = 128'({m_r_id, m_r_data, m_r_resp, m_r_last, m_r_valid});
        if (md_ph == 1) begin
            if (md_g == 1) begin
                e_mar = 128'({ifu_ar_id, ifu_ar_addr, ifu_ar_len, ifu_ar_size, ifu_ar_burst, ifu_ar_valid});
                e_iar = m_ar_ready;
            end else begin
                e_mar = 128'({lsu_ar_id, lsu_ar_addr, lsu_ar_len, lsu_ar_size, lsu_ar_burst, lsu_ar_valid});
                e_lar = m_ar_ready;
            end
        end else if (md_ph == 2) begin
            if (md_g == 1) begin e_ir = rb; e_mrr = ifu_r_ready; end
            else begin e_lr = rb; e_mrr = lsu_r_ready; end
        end
        if (en) begin
            chk("m_ar", 128'({m_ar_id, m_ar_addr, m_ar_len, m_ar_size, m_ar_burst, m_ar_valid}), e_mar);
            chk("ifu_ar_ready", 128'(ifu_ar_ready), 128'(e_iar));
            chk("lsu_ar_ready", 128'(lsu_ar_ready), 128'(e_lar));
            chk("ifu_r", 128'({ifu_r_id, ifu_r_data, ifu_r_resp, ifu_r_last, ifu_r_valid}), e_ir);
            chk("lsu_r", 128'({lsu_r_id, lsu_r_data, lsu_r_resp, lsu_r_last, lsu_r_valid}), e_lr);
            chk("m_r_ready", 128'(m_r_ready), 128'(e_mrr));
            chk("busy", 128'(busy), 128'(md_ph != 0));
            chk("rd_err", 128'(rd_err), 128'(md_err));
        end
        if (rst) begin
            md_ph = 0; md_lg = 1; md_cnt = 0; md_err = 1'b0;
        end else if (md_ph == 0) begin
            if (m_r_valid) md_err = 1'b1;
            if (ifu_ar_valid && lsu_ar_valid) md_g = (md_lg == 1) ? 2 : 1;
            else if (lsu_ar_valid) md_g = 2;
            else if (ifu_ar_valid) md_g = 1;
            if (ifu_ar_valid || lsu_ar_valid) begin md_lg = md_g; md_ph = 1; end
        end else if (md_ph == 1) begin
            if (m_r_valid) md_err = 1'b1;
            gv = (md_g == 1) ? ifu_ar_valid : lsu_ar_valid;
            if (gv && m_ar_ready) begin
                md_len = int'((md_g == 1) ? ifu_ar_len : lsu_ar_len);
                md_id = (md_g == 1) ? ifu_ar_id : lsu_ar_id;
                md_cnt = 0;
                md_ph = 2;
            end
        end else begin
            rdy = (md_g == 1) ? ifu_r_ready : lsu_r_ready;
            if (m_r_valid && m_r_id != md_id) md_err = 1'b1;
            if (m_r_valid && rdy) begin
                if (m_r_last != (md_cnt == md_len)) md_err = 1'b1;
                md_cnt++;
                if (m_r_last) md_ph = 0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        s_busy = busy; s_err = rd_err; s_mav = m_ar_valid; s_iarr = ifu_ar_ready;
        s_larr = lsu_ar_ready; s_irv = ifu_r_valid; s_lrv = lsu_r_valid; s_mrr = m_r_ready;
        s_maddr = m_ar_addr; s_mid = m_ar_id; s_ird = ifu_r_data;
        if (rnd) begin
            if (rst) begin
                ifu_req = 0; lsu_req = 0; s_act = 0;
            end else begin
                if (ifu_ar_valid && ifu_ar_ready) ifu_req = 0;
                if (lsu_ar_valid && lsu_ar_ready) lsu_req = 0;
                if (s_act && m_r_valid && m_r_ready) begin
                    s_beat++;
                    if (m_r_last) s_act = 0;
                end
                if (m_ar_valid && m_ar_ready) begin
                    s_act = 1; s_id = m_ar_id; s_len = int'(m_ar_len); s_beat = 0;
                end
            end
        end
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        ifu_ar_id = '0; ifu_ar_addr = '0; ifu_ar_len = '0; ifu_ar_size = '0; ifu_ar_burst = '0;
        ifu_ar_valid = 0; ifu_r_ready = 0;
        lsu_ar_id = '0; lsu_ar_addr = '0; lsu_ar_len = '0; lsu_ar_size = '0; lsu_ar_burst = '0;
        lsu_ar_valid = 0; lsu_r_ready = 0;
        m_ar_ready = 0; m_r_id = '0; m_r_data = '0; m_r_resp = '0; m_r_last = 0; m_r_valid = 0;
    endtask

    task automatic do_reset();
        clr_in(); rst = 1; step(); rst = 0;
    endtask

    task automatic beat(input logic [ID_W-1:0] id, input logic last, input bit to_lsu);
        m_r_valid = 1; m_r_id = id; m_r_last = last; m_r_data = {$urandom, $urandom};
        ifu_r_ready = !to_lsu; lsu_r_ready = to_lsu;
        step();
        m_r_valid = 0; m_r_last = 0;
    endtask

    task automatic gen();
        rst = ($urandom_range(0, 249) == 0);
        if (!ifu_req && $urandom_range(0, 3) == 0) begin
            ifu_req = 1; ifu_ar_id = 5'($urandom); ifu_ar_addr = {$urandom, $urandom};
            ifu_ar_len = 8'($urandom_range(0, 5)); ifu_ar_size = 3'($urandom); ifu_ar_burst = 2'($urandom);
        end
        if (!lsu_req && $urandom_range(0, 3) == 0) begin
            lsu_req = 1; lsu_ar_id = 5'($urandom); lsu_ar_addr = {$urandom, $urandom};
            lsu_ar_len = 8'($urandom_range(0, 5)); lsu_ar_size = 3'($urandom); lsu_ar_burst = 2'($urandom);
        end
        ifu_ar_valid = ifu_req; lsu_ar_valid = lsu_req;
        ifu_r_ready = ($urandom_range(0, 3) != 0); lsu_r_ready = ($urandom_range(0, 3) != 0);
        m_ar_ready = ($urandom_range(0, 2) != 0);
        m_r_data = {$urandom, $urandom}; m_r_resp = 2'($urandom);
        if (s_act) begin
            m_r_valid = ($urandom_range(0, 2) != 0);
            m_r_id = ($urandom_range(0, 59) == 0) ? (s_id ^ 5'd1) : s_id;
            m_r_last = (s_beat >= s_len) ^ ($urandom_range(0, 39) == 0);
        end else begin
            m_r_valid = ($urandom_range(0, 79) == 0);
            m_r_id = 5'($urandom); m_r_last = 1'($urandom);
        end
    endtask

    initial begin
        do_reset();
        en = 1;
        step();
        chk("rst_busy", 128'(s_busy), 128'(0));
        chk("rst_err", 128'(s_err), 128'(0));
        chk("rst_mav", 128'(s_mav), 128'(0));
        chk("rst_mrr", 128'(s_mrr), 128'(0));
        chk("rst_iarr", 128'(s_iarr), 128'(0));

        // IFU alone, single beat.
        ifu_ar_valid = 1; ifu_ar_addr = 64'h8000_0000; ifu_ar_len = 0; ifu_ar_id = 5'd3;
        ifu_ar_size = 3'd3; ifu_ar_burst = 2'd1; m_ar_ready = 1;
        step();
        chk("t1_idle_mav", 128'(s_mav), 128'(0));
        step();
        chk("t1_mav", 128'(s_mav), 128'(1));
        chk("t1_addr", 128'(s_maddr), 128'(64'h8000_0000));
        chk("t1_iarr", 128'(s_iarr), 128'(1));
        ifu_ar_valid = 0; m_ar_ready = 0;
        m_r_valid = 1; m_r_id = 5'd3; m_r_data = 64'hDEAD_BEEF; m_r_last = 1; ifu_r_ready = 1;
        step();
        chk("t1_irv", 128'(s_irv), 128'(1));
        chk("t1_data", 128'(s_ird), 128'(64'hDEAD_BEEF));
        chk("t1_lrv", 128'(s_lrv), 128'(0));
        chk("t1_busy", 128'(s_busy), 128'(1));
        clr_in(); step();
        chk("t1_busy_after", 128'(s_busy), 128'(0));
        chk("t1_err", 128'(s_err), 128'(0));

        // Simultaneous pairs alternate LSU, IFU, LSU, IFU.
        do_reset();
        for (int p = 0; p < 2; p++) begin
            ifu_ar_valid = 1; ifu_ar_id = 5'd1; lsu_ar_valid = 1; lsu_ar_id = 5'd2; m_ar_ready = 1;
            step();
            step();
            chk("t2_first_lsu", 128'(s_mid), 128'(5'd2));
            chk("t2_first_larr", 128'(s_larr), 128'(1));
            lsu_ar_valid = 0;
            beat(5'd2, 1'b1, 1'b1);
            step();
            chk("t2_gap", 128'(s_mav), 128'(0));
            step();
            chk("t2_then_ifu", 128'(s_mid), 128'(5'd1));
            chk("t2_iarr", 128'(s_iarr), 128'(1));
            ifu_ar_valid = 0;
            beat(5'd1, 1'b1, 1'b0);
        end

        // LSU burst len=3 with AR stall and toggling r_ready.
        clr_in();
        lsu_ar_valid = 1; lsu_ar_len = 8'd3; lsu_ar_id = 5'd7;
        step();
        for (int i = 0; i < 4; i++) step();
        m_ar_ready = 1;
        step();
        chk("t3_ar_hs", 128'(s_larr & s_mav), 128'(1));
        begin
            int fwd, ifu_act;
            fwd = 0; ifu_act = 0;
            lsu_ar_valid = 0; m_ar_ready = 0;
            for (int i = 0; i < 20 && fwd < 4; i++) begin
                m_r_valid = 1; m_r_id = 5'd7; m_r_last = (fwd == 3); m_r_data = {$urandom, $urandom};
                lsu_r_ready = i[0];
                step();
                if (s_lrv && s_mrr) fwd++;
                if (s_irv) ifu_act++;
            end
            chk("t3_beats", 128'(fwd), 128'(4));
            chk("t3_ifu_quiet", 128'(ifu_act), 128'(0));
        end
        clr_in(); step();
        chk("t3_err", 128'(s_err), 128'(0));
        chk("t3_busy", 128'(s_busy), 128'(0));

        // Early last: len=3, last on the second beat.
        lsu_ar_valid = 1; lsu_ar_len = 8'd3; lsu_ar_id = 5'd4; m_ar_ready = 1;
        step(); step();
        lsu_ar_valid = 0;
        beat(5'd4, 1'b0, 1'b1);
        beat(5'd4, 1'b1, 1'b1);
        clr_in(); step();
        chk("t4_err", 128'(s_err), 128'(1));
        chk("t4_idle", 128'(s_busy), 128'(0));
        step();
        chk("t4_sticky", 128'(s_err), 128'(1));

        // Stray beat in IDLE.
        do_reset();
        m_r_valid = 1; m_r_id = 5'd9;
        step();
        chk("t5_mrr", 128'(s_mrr), 128'(0));
        chk("t5_rv", 128'({s_irv, s_lrv}), 128'(0));
        clr_in(); step();
        chk("t5_err", 128'(s_err), 128'(1));

        // Reset in the middle of an LSU burst (rd_err is still set from the stray).
        lsu_ar_valid = 1; lsu_ar_len = 8'd3; lsu_ar_id = 5'd6; m_ar_ready = 1;
        step(); step();
        lsu_ar_valid = 0;
        beat(5'd6, 1'b0, 1'b1);
        do_reset();
        step();
        chk("t6_busy", 128'(s_busy), 128'(0));
        chk("t6_err", 128'(s_err), 128'(0));
        chk("t6_vr", 128'({s_mav, s_mrr, s_iarr, s_larr, s_irv, s_lrv}), 128'(0));
        ifu_ar_valid = 1; ifu_ar_id = 5'd9; ifu_ar_len = 0; m_ar_ready = 1;
        step(); step();
        chk("t6_ifu_ar", 128'({s_mav, s_iarr}), 128'(2'b11));
        ifu_ar_valid = 0;
        beat(5'd9, 1'b1, 1'b0);
        chk("t6_ifu_r", 128'(s_irv), 128'(1));
        clr_in(); step();
        chk("t6_done", 128'({s_busy, s_err}), 128'(0));

        // Randomized traffic with occasional protocol faults and resets.
        do_reset();
        rnd = 1; ifu_req = 0; lsu_req = 0; s_act = 0; s_id = '0; s_len = 0; s_beat = 0;
        for (int c = 0; c < 4000; c++) begin
            gen();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Two-master read-channel arbiter that shares the core's single AXI read port between the IFU (instruction fetch) and the LSU (load path).
- Sits between the pipeline fetch/memory units and the address-decode crossbar that splits traffic to SoC and CLINT.
- Grants the read port per transaction, locking from AR handshake to the final R beat, with round-robin on ties.
- Also counts R beats against ARLEN and flags protocol errors.

Parameters:
ID_W, 5, AXI ID width
ADDR_W, 64, address width
DATA_W, 64, read data width

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
ifu_ar_id/addr/len/size/burst  in  ID_W/ADDR_W/8/3/2  IFU AR payload
ifu_ar_valid  in  1  IFU AR valid
ifu_ar_ready  out  1  IFU AR ready
ifu_r_id/data/resp/last  out  ID_W/DATA_W/2/1  IFU R payload
ifu_r_valid  out  1  IFU R valid
ifu_r_ready  in  1  IFU R ready
lsu_ar_*, lsu_r_*  same as ifu_*  LSU request/response bundle
m_ar_id/addr/len/size/burst  out  ID_W/ADDR_W/8/3/2  AR payload to crossbar
m_ar_valid  out  1  AR valid to crossbar
m_ar_ready  in  1  crossbar AR ready
m_r_id/data/resp/last  in  ID_W/DATA_W/2/1  R payload from crossbar
m_r_valid  in  1  R valid from crossbar
m_r_ready  out  1  R ready to crossbar
busy  out  1  state != IDLE
rd_err  out  1  sticky protocol error flag

Behaviour:
- Clock and reset: single clock domain, clk. rst is synchronous and active-high.
- Reset values: state=IDLE; last_grant=IFU (first tie therefore goes to LSU); beat_cnt=0; rd_err=0.
  - All valid and ready outputs are 0.
  - All payload outputs are 0.
- States: IDLE, IFU_AR, IFU_R, LSU_AR, LSU_R.
- IDLE transitions:
  - Only lsu_ar_valid -> LSU_AR.
  - Only ifu_ar_valid -> IFU_AR.
  - Both -> grant the master that is not last_grant; last_grant updates on the same edge.
  - Neither -> stay in IDLE.
  - Arbitration costs exactly 1 cycle: m_ar_valid never asserts in IDLE.
- X_AR (X = granted master):
  - m_ar_* = X_ar_*, m_ar_valid = X_ar_valid, X_ar_ready = m_ar_ready.
  - Non-granted ar_ready = 0.
  - On m_ar_valid & m_ar_ready: latch len into len_q, clear beat_cnt, latch id into id_q, go to X_R.
  - If X drops valid before handshake (AXI violation), stay in X_AR.
- X_R:
  - X_r_* = m_r_*, X_r_valid = m_r_valid, m_r_ready = X_r_ready.
  - Non-granted r_valid = 0 and its r payload = 0.
  - Both ar_ready = 0.
- Beat counting: beat_cnt (9-bit) increments on each m_r_valid & m_r_ready.
- Leaving X_R: on a handshake with m_r_last=1, go to IDLE. The next grant decision happens in IDLE on the following cycle, so there is no back-to-back AR.
- rd_err (sticky until rst) sets on any of:
  - m_r_last on a beat where beat_cnt != len_q;
  - beat_cnt reaches len_q without m_r_last;
  - m_r_valid with m_r_id != id_q in X_R;
  - m_r_valid in IDLE or X_AR.
  - Unexpected beats in IDLE/X_AR are not forwarded and m_r_ready=0.
- Outside the X_AR/X_R window: m_ar_* payload = 0, m_ar_valid = 0, m_r_ready = 0.
- Reset mid-transaction: return to IDLE on the next edge. Any outstanding beats are discarded and rd_err is cleared. Upstream is expected to be reset together.
- Latency: request to m_ar_valid = 1 cycle. R path is combinational pass-through (0 cycles).

Test Plan:
- IFU-only request, addr=0x8000_0000, len=0 → m_ar_valid rises 1 cycle after ifu_ar_valid; 1 beat returned, data 0xDEAD_BEEF routed to IFU; busy drops the cycle after last.
- Simultaneous IFU and LSU requests after reset → LSU granted first; after its last beat, IDLE for 1 cycle, then IFU granted; a second simultaneous pair goes LSU, IFU again (alternation).
- LSU burst len=3 with m_ar_ready held low 4 cycles, and r_ready toggled by LSU → exactly 4 beats forwarded, no IFU R activity; rd_err=0.
- Early last: len=3 but m_r_last on beat 2 → rd_err=1 and stays 1; arbiter returns to IDLE.
- Stray R: m_r_valid=1 in IDLE → m_r_ready=0, no upstream r_valid, rd_err=1.
- rst asserted in LSU_R mid-burst → next cycle state=IDLE, busy=0, rd_err=0, all valid/ready outputs 0; a new IFU request is then served normally.
